hazard_control: RTL and testbench
=================================

// Module: hazard_control
// PURPOSE
//  Pipeline sequencer for the 5-stage MIPS core. Sits beside the ID stage and issues per-stage write-enable and flush controls.
//  Handles three cases: load-use stalls, taken branch/jump flushes, and memory-busy freezes.
//  Its outputs drive the PC register, the IF/ID register, the stage_id output register (bubble insert) and the EX/MEM register.
// PARAMETERS
//  LOAD_LATENCY  1  bubble cycles per load-use hazard (1..7)
//  CNT_W         3  width of stall down-counter
// PORTS
//  clock          in   1  system clock, all state on posedge
//  reset          in   1  synchronous, active-high
//  id_rs          in   5  rs field of instruction in ID (instr[25:21])
//  id_rt          in   5  rt field of instruction in ID (instr[20:16])
//  id_usesRt      in   1  ID instruction reads rt (R-type, store, beq/bne)
//  ex_memRead     in   1  instruction in EX is a load
//  ex_rt          in   5  destination rt of instruction in EX
//  ex_branchTaken in   1  branch/jump resolved taken in EX
//  mem_busy       in   1  data memory not ready, freeze whole pipe
//  pcWrite        out  1  PC register enable
//  ifidWrite      out  1  IF/ID register enable
//  idexBubble     out  1  stage_id loads all-zero control (NOP) instead of decoded control
//  exmemWrite     out  1  EX/MEM register enable
//  ifidFlush      out  1  clear IF/ID to NOP
//  idexFlush      out  1  clear ID/EX to NOP
// BEHAVIOUR
//  States: RUN, STALL, WAIT. Registers: state, cnt[CNT_W-1:0], ret_state (state to resume after WAIT).
//  Outputs are combinational from state + current inputs; next state is registered.
//  hazard = ex_memRead && ex_rt!=0 && (ex_rt==id_rs || (id_usesRt && ex_rt==id_rt)).
//  Priority in every state: reset > mem_busy > ex_branchTaken > STALL countdown > hazard.
//  reset high: state<=RUN, cnt<=0, ret_state<=RUN. Outputs while reset high: pcWrite=0, ifidWrite=0, exmemWrite=0, ifidFlush=1, idexFlush=1, idexBubble=1.
//  mem_busy=1 (any state): all enables 0, flushes 0, idexBubble=0. Transitions: state<=WAIT; ret_state<=state unless already WAIT; cnt frozen.
//  WAIT and mem_busy=0: state<=ret_state. Evaluation in that cycle proceeds as in ret_state, so a pending branch held in EX is acted on then.
//  ex_branchTaken (not busy): pcWrite=1, ifidWrite=1, exmemWrite=1, ifidFlush=1, idexFlush=1. state<=RUN, cnt<=0; an in-progress STALL is abandoned.
//  RUN, hazard, no branch: pcWrite=0, ifidWrite=0, idexBubble=1, exmemWrite=1.
//    If LOAD_LATENCY>1: state<=STALL, cnt<=LOAD_LATENCY-2. Otherwise stay in RUN.
//  STALL: same outputs as the hazard cycle. cnt==0 -> state<=RUN, else cnt<=cnt-1. hazard is ignored while in STALL.
//  RUN, no event: pcWrite=ifidWrite=exmemWrite=1; flushes and bubble 0.
//  Latency: a hazard costs exactly LOAD_LATENCY bubble cycles. A taken branch costs 2 flushed slots and no extra cycle.
//  ex_rt==0 never stalls. Simultaneous hazard and branch: the branch wins and no bubble is inserted.
//  Reset asserted mid-STALL or mid-WAIT: returns to RUN on the next edge.
// CONFIGURATION
//  HAZARD_STATS_EN defined: adds outputs stallCount[31:0] and flushCount[31:0].
//    Both cleared by reset and saturating at 32'hFFFFFFFF.
//    stallCount increments on each cycle with idexBubble=1 and not busy; flushCount increments on each cycle with ifidFlush=1 and not reset.
//  HAZARD_STATS_EN undefined: the ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  hazard_defs.vh (shared include): state encodings ST_RUN=2'd0, ST_STALL=2'd1, ST_WAIT=2'd2; REG_ZERO=5'd0.
//  Sub-module hazard_detect: combinational load-use comparator (id_rs, id_rt, id_usesRt, ex_memRead, ex_rt -> hazard).
//  FSM, counter and output decode live in hazard_control.
// TESTING
//  1 reset=1 for 2 cycles -> pcWrite=0, ifidFlush=idexFlush=1; after release state RUN, all enables 1.
//  2 ex_memRead=1, ex_rt=8, id_rs=8, LOAD_LATENCY=1 -> one cycle pcWrite=0, idexBubble=1, then RUN.
//  3 same stimulus with LOAD_LATENCY=3 -> exactly 3 bubble cycles; ex_rt=0 or id_rt match with id_usesRt=0 -> no stall.
//  4 ex_branchTaken=1 together with hazard -> ifidFlush=idexFlush=1, pcWrite=1, idexBubble=0; state RUN.
//  5 mem_busy=1 for 4 cycles during STALL with cnt=1 -> enables 0; on release, 2 more bubbles complete, then RUN.
//  6 HAZARD_STATS_EN: run scenarios 2 and 4 -> stallCount=1, flushCount=1; force counters near max -> saturate at 32'hFFFFFFFF.

Source files
------------

// File: rtl/hazard_control_pkg.sv
// Shared state encodings and constants for the hazard_control pipeline sequencer.
package hazard_control_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_control_if.sv
// Hazard-unit bundle: ID/EX hazard inputs and per-stage enable/flush controls.
interface hazard_control_if;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_usesRt;
  logic       ex_memRead;
  logic [4:0] ex_rt;
  logic       ex_branchTaken;
  logic       mem_busy;
  logic       pcWrite;
  logic       ifidWrite;
  logic       idexBubble;
  logic       exmemWrite;
  logic       ifidFlush;
  logic       idexFlush;

  modport master (
    output id_rs, id_rt, id_usesRt, ex_memRead, ex_rt, ex_branchTaken, mem_busy,
    input  pcWrite, ifidWrite, idexBubble, exmemWrite, ifidFlush, idexFlush
  );

  modport slave (
    input  id_rs, id_rt, id_usesRt, ex_memRead, ex_rt, ex_branchTaken, mem_busy,
    output pcWrite, ifidWrite, idexBubble, exmemWrite, ifidFlush, idexFlush
  );
endinterface

// File: rtl/hazard_control_detect.sv
// Load-use comparator: flags an ID instruction reading the register a load in EX writes.
module hazard_detect
  import hazard_control_pkg::*;
(
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       id_usesRt_i,
  input  logic       ex_memRead_i,
  input  logic [4:0] ex_rt_i,
  output logic       hazard_o
);

  // $zero is hard-wired, so a load targeting it never creates a dependency.
  assign hazard_o = ex_memRead_i && (ex_rt_i != REG_ZERO) &&
                    ((ex_rt_i == id_rs_i) || (id_usesRt_i && (ex_rt_i == id_rt_i)));

endmodule

// File: rtl/hazard_control.sv
// Pipeline sequencer: load-use stalls, taken-branch flushes and memory-busy freezes.
// Optional HAZARD_STATS_EN adds saturating stallCount/flushCount outputs.
module hazard_control
  import hazard_control_pkg::*;
#(
  parameter int LOAD_LATENCY = 1,
  parameter int CNT_W        = 3
) (
  input  logic              clock,
  input  logic              reset,
  hazard_control_if.slave   hc
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]       stallCount,
  output logic [31:0]       flushCount
`endif
);

  localparam logic [CNT_W-1:0] STALL_INIT =
    (LOAD_LATENCY > 1) ? CNT_W'(LOAD_LATENCY - 2) : '0;

  state_e           state_q, state_d;
  state_e           ret_q, ret_d;
  state_e           eff_state;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hazard;

  logic pc_we, ifid_we, bubble, exmem_we, ifid_fl, idex_fl;

  hazard_detect u_detect (
    .id_rs_i      (hc.id_rs),
    .id_rt_i      (hc.id_rt),
    .id_usesRt_i  (hc.id_usesRt),
    .ex_memRead_i (hc.ex_memRead),
    .ex_rt_i      (hc.ex_rt),
    .hazard_o     (hazard)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_RUN;
      ret_q   <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
    end
  end

  // Leaving WAIT evaluates as the frozen state, so nothing pending is lost.
  assign eff_state = (state_q == ST_WAIT) ? ret_q : state_q;

  always_comb begin
    pc_we    = 1'b1;
    ifid_we  = 1'b1;
    exmem_we = 1'b1;
    bubble   = 1'b0;
    ifid_fl  = 1'b0;
    idex_fl  = 1'b0;
    state_d  = state_q;
    ret_d    = ret_q;
    cnt_d    = cnt_q;

    if (reset) begin
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      exmem_we = 1'b0;
      bubble   = 1'b1;
      ifid_fl  = 1'b1;
      idex_fl  = 1'b1;
      state_d  = ST_RUN;
      ret_d    = ST_RUN;
      cnt_d    = '0;
    end else if (hc.mem_busy) begin
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      exmem_we = 1'b0;
      state_d  = ST_WAIT;
      if (state_q != ST_WAIT) ret_d = state_q;
    end else if (hc.ex_branchTaken) begin
      ifid_fl = 1'b1;
      idex_fl = 1'b1;
      state_d = ST_RUN;
      cnt_d   = '0;
    end else if (eff_state == ST_STALL) begin
      pc_we   = 1'b0;
      ifid_we = 1'b0;
      bubble  = 1'b1;
      if (cnt_q == '0) begin
        state_d = ST_RUN;
      end else begin
        state_d = ST_STALL;
        cnt_d   = cnt_q - CNT_W'(1);
      end
    end else if (hazard) begin
      pc_we   = 1'b0;
      ifid_we = 1'b0;
      bubble  = 1'b1;
      if (LOAD_LATENCY > 1) begin
        state_d = ST_STALL;
        cnt_d   = STALL_INIT;
      end else begin
        state_d = ST_RUN;
      end
    end else begin
      state_d = ST_RUN;
    end
  end

  assign hc.pcWrite    = pc_we;
  assign hc.ifidWrite  = ifid_we;
  assign hc.idexBubble = bubble;
  assign hc.exmemWrite = exmem_we;
  assign hc.ifidFlush  = ifid_fl;
  assign hc.idexFlush  = idex_fl;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (bubble && !hc.mem_busy && (stall_cnt_q != 32'hFFFF_FFFF))
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (ifid_fl && (flush_cnt_q != 32'hFFFF_FFFF))
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stallCount = stall_cnt_q;
  assign flushCount = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_control.sv
// Directed bench for hazard_control: LOAD_LATENCY=1 and LOAD_LATENCY=3 instances.
module tb_hazard_control;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_control_if if1 ();
  hazard_control_if if3 ();

`ifdef HAZARD_STATS_EN
  logic [31:0] sc1, fc1, sc3, fc3;
`endif

  hazard_control #(.LOAD_LATENCY(1), .CNT_W(3)) dut1 (
    .clock (clk),
    .reset (rst),
    .hc    (if1)
`ifdef HAZARD_STATS_EN
    , .stallCount (sc1), .flushCount (fc1)
`endif
  );

  hazard_control #(.LOAD_LATENCY(3), .CNT_W(3)) dut3 (
    .clock (clk),
    .reset (rst),
    .hc    (if3)
`ifdef HAZARD_STATS_EN
    , .stallCount (sc3), .flushCount (fc3)
`endif
  );

  // Expected output order: {pcWrite, ifidWrite, idexBubble, exmemWrite, ifidFlush, idexFlush}
  localparam logic [5:0] O_RUN = 6'b110100;
  localparam logic [5:0] O_RST = 6'b001011;
  localparam logic [5:0] O_BUB = 6'b001100;
  localparam logic [5:0] O_BR  = 6'b110111;
  localparam logic [5:0] O_BSY = 6'b000000;

  typedef struct {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses;
    logic       mr;
    logic [4:0] ert;
    logic       br;
    logic       busy;
    logic [5:0] exp;
    string      name;
  } vec_t;

  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                              input logic uses, input logic mr, input logic [4:0] ert,
                              input logic br, input logic busy, input logic [5:0] exp,
                              input string name);
    vec_t v;
    v.rst = r; v.rs = rs; v.rt = rt; v.uses = uses; v.mr = mr; v.ert = ert;
    v.br = br; v.busy = busy; v.exp = exp; v.name = name;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Drives both instances with one cycle of inputs, checks the selected one mid-cycle.
  task automatic apply(input vec_t v, input bit use3);
    logic [5:0] got;
    rst = v.rst;
    if1.id_rs = v.rs; if1.id_rt = v.rt; if1.id_usesRt = v.uses; if1.ex_memRead = v.mr;
    if1.ex_rt = v.ert; if1.ex_branchTaken = v.br; if1.mem_busy = v.busy;
    if3.id_rs = v.rs; if3.id_rt = v.rt; if3.id_usesRt = v.uses; if3.ex_memRead = v.mr;
    if3.ex_rt = v.ert; if3.ex_branchTaken = v.br; if3.mem_busy = v.busy;
    @(negedge clk);
    if (use3)
      got = {if3.pcWrite, if3.ifidWrite, if3.idexBubble, if3.exmemWrite, if3.ifidFlush, if3.idexFlush};
    else
      got = {if1.pcWrite, if1.ifidWrite, if1.idexBubble, if1.exmemWrite, if1.ifidFlush, if1.idexFlush};
    check(v.name, {26'd0, got}, {26'd0, v.exp});
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[18];
  vec_t idle, hz, hzbr, rstv;

  initial begin
    idle = mk(0, 5'd1, 5'd2, 1, 0, 5'd0, 0, 0, O_RUN, "idle");
    hz   = mk(0, 5'd8, 5'd2, 1, 1, 5'd8, 0, 0, O_BUB, "hazard_rs");
    hzbr = mk(0, 5'd8, 5'd2, 1, 1, 5'd8, 1, 0, O_BR,  "hazard_with_branch");
    rstv = mk(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, O_RST, "reset");

    tbl[0]  = mk(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, O_RST, "reset_c0");
    tbl[1]  = mk(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, O_RST, "reset_c1");
    tbl[2]  = mk(0, 5'd1, 5'd2, 1, 0, 5'd0, 0, 0, O_RUN, "run_after_reset");
    tbl[3]  = mk(0, 5'd8, 5'd2, 1, 1, 5'd8, 0, 0, O_BUB, "ll1_hazard_rs");
    tbl[4]  = mk(0, 5'd1, 5'd2, 1, 0, 5'd0, 0, 0, O_RUN, "ll1_back_to_run");
    tbl[5]  = mk(0, 5'd0, 5'd0, 1, 1, 5'd0, 0, 0, O_RUN, "ex_rt_zero_no_stall");
    tbl[6]  = mk(0, 5'd3, 5'd9, 0, 1, 5'd9, 0, 0, O_RUN, "rt_match_not_used");
    tbl[7]  = mk(0, 5'd3, 5'd9, 1, 1, 5'd9, 0, 0, O_BUB, "rt_match_used");
    tbl[8]  = mk(0, 5'd8, 5'd2, 1, 1, 5'd8, 1, 0, O_BR,  "branch_beats_hazard");
    tbl[9]  = mk(0, 5'd1, 5'd2, 1, 0, 5'd0, 0, 0, O_RUN, "run_after_branch");
    tbl[10] = mk(0, 5'd1, 5'd2, 1, 0, 5'd0, 0, 1, O_BSY, "busy_freeze");
    tbl[11] = mk(0, 5'd8, 5'd2, 1, 1, 5'd8, 0, 1, O_BSY, "busy_beats_hazard");
    tbl[12] = mk(0, 5'd1, 5'd2, 1, 0, 5'd0, 0, 0, O_RUN, "busy_release_run");
    tbl[13] = mk(0, 5'd1, 5'd2, 1, 0, 5'd0, 1, 1, O_BSY, "busy_beats_branch");
    tbl[14] = mk(0, 5'd1, 5'd2, 1, 0, 5'd0, 1, 0, O_BR,  "held_branch_after_wait");
    tbl[15] = mk(0, 5'd6, 5'd7, 1, 1, 5'd5, 0, 0, O_RUN, "load_no_match");
    tbl[16] = mk(1, 5'd8, 5'd2, 1, 1, 5'd8, 0, 0, O_RST, "reset_beats_hazard");
    tbl[17] = mk(0, 5'd1, 5'd2, 1, 0, 5'd0, 0, 0, O_RUN, "run_after_reset2");

    for (int i = 0; i < 18; i++) apply(tbl[i], 1'b0);

    // LOAD_LATENCY=3: exactly three bubbles.
    apply(rstv, 1'b1);
    hz.name = "ll3_bubble1"; apply(hz, 1'b1);
    idle.exp = O_BUB; idle.name = "ll3_bubble2"; apply(idle, 1'b1);
    idle.name = "ll3_bubble3"; apply(idle, 1'b1);
    idle.exp = O_RUN; idle.name = "ll3_resume"; apply(idle, 1'b1);

    apply(mk(0, 5'd0, 5'd0, 1, 1, 5'd0, 0, 0, O_RUN, "ll3_ex_rt_zero"), 1'b1);
    apply(mk(0, 5'd3, 5'd9, 0, 1, 5'd9, 0, 0, O_RUN, "ll3_rt_unused"), 1'b1);

    // Freeze for 4 cycles during STALL with cnt=1, then two more bubbles.
    hz.name = "ll3_busy_hazard"; apply(hz, 1'b1);
    for (int i = 0; i < 4; i++)
      apply(mk(0, 5'd1, 5'd2, 1, 0, 5'd0, 0, 1, O_BSY, "ll3_busy_in_stall"), 1'b1);
    idle.exp = O_BUB; idle.name = "ll3_post_busy_bubble1"; apply(idle, 1'b1);
    idle.name = "ll3_post_busy_bubble2"; apply(idle, 1'b1);
    idle.exp = O_RUN; idle.name = "ll3_post_busy_run"; apply(idle, 1'b1);

    // Branch abandons an in-progress stall.
    hz.name = "ll3_stall_then_branch"; apply(hz, 1'b1);
    apply(mk(0, 5'd1, 5'd2, 1, 0, 5'd0, 1, 0, O_BR, "ll3_branch_in_stall"), 1'b1);
    idle.name = "ll3_stall_abandoned"; apply(idle, 1'b1);

    // Reset mid-STALL returns to RUN.
    hz.name = "ll3_stall_then_reset"; apply(hz, 1'b1);
    rstv.name = "ll3_reset_in_stall"; apply(rstv, 1'b1);
    idle.name = "ll3_run_after_reset"; apply(idle, 1'b1);

`ifdef HAZARD_STATS_EN
    apply(rstv, 1'b0);
    hz.name = "stats_hazard"; apply(hz, 1'b0);
    idle.name = "stats_idle"; apply(idle, 1'b0);
    apply(hzbr, 1'b0);
    apply(idle, 1'b0);
    check("stallCount_one", sc1, 32'd1);
    check("flushCount_one", fc1, 32'd1);

    @(negedge clk);
    force dut1.stall_cnt_q = 32'hFFFF_FFFE;
    release dut1.stall_cnt_q;
    @(posedge clk); #1;
    hz.name = "sat_hazard1"; apply(hz, 1'b0);
    hz.name = "sat_hazard2"; apply(hz, 1'b0);
    check("stallCount_saturate", sc1, 32'hFFFF_FFFF);

    @(negedge clk);
    force dut1.flush_cnt_q = 32'hFFFF_FFFF;
    release dut1.flush_cnt_q;
    @(posedge clk); #1;
    apply(hzbr, 1'b0);
    check("flushCount_saturate", fc1, 32'hFFFF_FFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
